neural_layer_seq: RTL and testbench

Sequencer that time-multiplexes one two-input threshold neuron (`CALC_NEURAL`: two fixed-point multiplies, add, fire if the sum is positive and non-zero) across `NEURONS` neurons of a layer.

- It holds a per-neuron coefficient bank loaded by the host.
- It accepts one input pair per layer evaluation over a valid/ready handshake.
- It evaluates neurons in index order, one per cycle.
- It returns the layer's fire bits as one vector, also over a valid/ready handshake.
- It sits between the input/feature source and the next layer or the host readback.

---
 rtl/neural_pkg.sv | 19 +
 rtl/neural_calc.sv | 30 +++
 rtl/neural_coef_bank.sv | 51 +++++
 rtl/neural_layer_seq.sv | 110 +++++++++++
 tb/tb_neural_layer_seq.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/neural_pkg.sv
// Shared types and Q8.8 constants for the time-multiplexed neural layer sequencer.
package neural_pkg;

  localparam int FRAC_BITS = 8;
  localparam logic [15:0] FIX_ONE     = 16'h0100;
  localparam logic [15:0] FIX_NEG_ONE = 16'hFF00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } coef_pair_t;

endpackage

// File: rtl/neural_calc.sv
// Combinational two-input threshold neuron: Q8.8 multiplies and add, wrapping at WIDTH bits.
module CALC_NEURAL
  import neural_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_x0,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_w0,
  input  logic [WIDTH-1:0] i_w1,
  output logic             o_fire
);

  logic signed [2*WIDTH-1:0] w_p0;
  logic signed [2*WIDTH-1:0] w_p1;
  logic        [WIDTH-1:0]   w_sum;
  logic                      w_unused_bits;

  assign w_p0 = $signed(i_x0) * $signed(i_w0);
  assign w_p1 = $signed(i_x1) * $signed(i_w1);

  // Drop the extra fraction bits and the integer overflow bits; the sum wraps too.
  assign w_sum = w_p0[WIDTH+FRAC_BITS-1:FRAC_BITS] + w_p1[WIDTH+FRAC_BITS-1:FRAC_BITS];

  assign o_fire = (w_sum != '0) && !w_sum[WIDTH-1];

  assign w_unused_bits = ^{w_p0[2*WIDTH-1:WIDTH+FRAC_BITS], w_p0[FRAC_BITS-1:0],
                           w_p1[2*WIDTH-1:WIDTH+FRAC_BITS], w_p1[FRAC_BITS-1:0]};

endmodule

// File: rtl/neural_coef_bank.sv
// Per-neuron coefficient register bank: guarded synchronous write, combinational read, drop-error pulse.
module neural_coef_bank #(
  parameter int WIDTH   = 16,
  parameter int NEURONS = 4,
  parameter int AW      = $clog2(NEURONS + 1),
  parameter int IW      = $clog2(NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic             i_wr_allow,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wa,
  input  logic [WIDTH-1:0] i_wb,
  input  logic [IW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_ra,
  output logic [WIDTH-1:0] o_rb,
  output logic             o_err
);

  logic [WIDTH-1:0] r_a [NEURONS];
  logic [WIDTH-1:0] r_b [NEURONS];
  logic             r_err;
  logic             w_in_range;
  logic             w_commit;

  assign w_in_range = (i_waddr < AW'(NEURONS));
  assign w_commit   = i_we && i_wr_allow && w_in_range;

  // Any write that cannot land is reported one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
      for (int i = 0; i < NEURONS; i++) begin
        r_a[i] <= '0;
        r_b[i] <= '0;
      end
    end else begin
      r_err <= i_we && !w_commit;
      if (w_commit) begin
        r_a[i_waddr[IW-1:0]] <= i_wa;
        r_b[i_waddr[IW-1:0]] <= i_wb;
      end
    end
  end

  assign o_ra  = r_a[i_raddr];
  assign o_rb  = r_b[i_raddr];
  assign o_err = r_err;

endmodule

// File: rtl/neural_layer_seq.sv
// Layer sequencer: accepts one input pair, evaluates NEURONS neurons one per cycle on a shared datapath.
module neural_layer_seq
  import neural_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NEURONS = 4,
  // One extra code point so an out-of-range neuron index can actually be presented.
  parameter int AW      = $clog2(NEURONS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coef_we,
  input  logic [AW-1:0]      coef_addr,
  input  logic [WIDTH-1:0]   coef_a,
  input  logic [WIDTH-1:0]   coef_b,
  output logic               coef_err,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NEURONS-1:0] out_bits,
  output logic               busy
);

  localparam int IW = $clog2(NEURONS);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_in_a;
  logic [WIDTH-1:0]   r_in_b;
  logic [IW-1:0]      r_idx;
  logic [NEURONS-1:0] r_bits;
  logic [WIDTH-1:0]   w_ca;
  logic [WIDTH-1:0]   w_cb;
  logic               w_fire;
  logic               w_accept;
  logic               w_last;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_last   = (r_idx == IW'(NEURONS - 1));

  neural_coef_bank #(
    .WIDTH   (WIDTH),
    .NEURONS (NEURONS),
    .AW      (AW),
    .IW      (IW)
  ) u_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (coef_we),
    .i_wr_allow (r_state != ST_RUN),
    .i_waddr    (coef_addr),
    .i_wa       (coef_a),
    .i_wb       (coef_b),
    .i_raddr    (r_idx),
    .o_ra       (w_ca),
    .o_rb       (w_cb),
    .o_err      (coef_err)
  );

  CALC_NEURAL #(
    .WIDTH (WIDTH)
  ) u_calc (
    .i_x0   (r_in_a),
    .i_x1   (r_in_b),
    .i_w0   (w_ca),
    .i_w1   (w_cb),
    .o_fire (w_fire)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_a <= '0;
      r_in_b <= '0;
      r_idx  <= '0;
      r_bits <= '0;
    end else if (w_accept) begin
      r_in_a <= in_a;
      r_in_b <= in_b;
      r_idx  <= '0;
      r_bits <= '0;
    end else if (r_state == ST_RUN) begin
      r_bits[r_idx] <= w_fire;
      r_idx         <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_bits  = r_bits;

endmodule

// File: tb/tb_neural_layer_seq.sv
// Directed table-driven bench for neural_layer_seq plus hand-written multi-cycle sequences.
module tb_neural_layer_seq;
  import neural_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NEURONS = 4;
  localparam int AW      = 3;

  logic               clk;
  logic               rst_n;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic [WIDTH-1:0]   coef_a;
  logic [WIDTH-1:0]   coef_b;
  logic               coef_err;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [NEURONS-1:0] out_bits;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  typedef struct packed {
    coef_pair_t [3:0] c;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [3:0]       exp;
  } vec_t;

  vec_t vecs [4];

  neural_layer_seq #(
    .WIDTH   (WIDTH),
    .NEURONS (NEURONS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_a    (coef_a),
    .coef_b    (coef_b),
    .coef_err  (coef_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic [15:0] a0, b0, a1, b1, a2, b2, a3, b3,
                                 input logic [15:0] a, b, input logic [3:0] exp);
    vec_t v;
    v.c[0] = '{a: a0, b: b0};
    v.c[1] = '{a: a1, b: b1};
    v.c[2] = '{a: a2, b: b2};
    v.c[3] = '{a: a3, b: b3};
    v.a    = a;
    v.b    = b;
    v.exp  = exp;
    return v;
  endfunction

  // Drives one write strobe for a cycle; returns the error flag seen right after it.
  task automatic writeCoef(input logic [AW-1:0] addr, input logic [15:0] a, input logic [15:0] b,
                           output logic err);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_a    = a;
    coef_b    = b;
    @(negedge clk);
    coef_we = 1'b0;
    err     = coef_err;
  endtask

  task automatic loadLayer(input vec_t v);
    logic err;
    for (int i = 0; i < NEURONS; i++) begin
      writeCoef(AW'(i), v.c[i].a, v.c[i].b, err);
      checkOutput("loadNoErr", {31'd0, err}, 32'd0);
    end
  endtask

  // Offers one input pair in IDLE and waits (bounded) for out_valid; lat counts cycles from the handshake.
  task automatic runLayer(input logic [15:0] a, input logic [15:0] b,
                          output logic [3:0] bits, output int lat);
    int n;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    bits = out_bits;
    lat  = n;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("backToIdle", {29'd0, out_valid, in_ready, busy}, {29'd0, 3'b010});
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [3:0] bits;
    int         lat;
    loadLayer(v);
    runLayer(v.a, v.b, bits, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd5);
    checkOutput({tag, "_bits"}, {28'd0, bits}, {28'd0, v.exp});
    consume();
  endtask

  logic [3:0]  bits;
  logic        err;
  logic        accNow;
  int          lat;
  int          pulses;
  int          nAcc;
  int          nRes;
  int          accCyc [3];
  logic [3:0]  res [3];
  logic [15:0] bbA [3];
  logic [15:0] bbB [3];
  logic [3:0]  bbExp [3];

  initial begin
    vecs[0] = mkVec(16'h0100, 16'h0000, 16'hFF00, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'hFF00,
                    16'h0100, 16'h0100, 4'b0001);
    vecs[1] = mkVec(16'h0100, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0200, 16'hFE00,
                    16'h0100, 16'h0080, 4'b1011);
    vecs[2] = mkVec(16'h7F00, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'hFF00,
                    16'h0200, 16'hFF00, 4'b1010);
    vecs[3] = mkVec(16'h4000, 16'h4000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                    16'h0200, 16'h0200, 4'b0010);
    bbA[0] = 16'h0100; bbB[0] = 16'h0080; bbExp[0] = 4'b1011;
    bbA[1] = 16'hFF00; bbB[1] = 16'hFF00; bbExp[1] = 4'b0100;
    bbA[2] = 16'h0000; bbB[2] = 16'h0100; bbExp[2] = 4'b0001;

    rst_n     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_a    = '0;
    coef_b    = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {26'd0, out_valid, busy, coef_err, 1'b0, out_bits == 4'b0 ? 1'b0 : 1'b1, 1'b0},
                32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetInReady", {31'd0, in_ready}, 32'd1);
    checkOutput("resetOutBits", {28'd0, out_bits}, 32'd0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold while out_ready stays low.
    loadLayer(vecs[1]);
    runLayer(vecs[1].a, vecs[1].b, bits, lat);
    checkOutput("bp_bits", {28'd0, bits}, {28'd0, vecs[1].exp});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_hold", {25'd0, out_valid, in_ready, busy, out_bits}, {25'd0, 3'b101, 4'b1011});
    end
    consume();

    // Write during RUN is dropped and flagged exactly once.
    loadLayer(vecs[0]);
    in_a     = 16'h0100;
    in_b     = 16'h0100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    writeCoef(3'd0, 16'hFF00, 16'h0000, err);
    checkOutput("runWrErrPulse", {31'd0, err}, 32'd1);
    pulses = 1;
    lat    = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (coef_err === 1'b1) pulses++;
    end
    checkOutput("runWrPulses", 32'(pulses), 32'd1);
    checkOutput("runWrBits", {28'd0, out_bits}, 32'b0001);
    consume();
    runLayer(16'h0100, 16'h0100, bits, lat);
    checkOutput("runWrNextBits", {28'd0, bits}, 32'b0001);
    consume();

    // Out-of-range address is dropped; aliasing onto neuron 0 would change the result.
    writeCoef(3'd4, 16'hFF00, 16'h0000, err);
    checkOutput("oorErr", {31'd0, err}, 32'd1);
    @(negedge clk);
    checkOutput("oorErrOnce", {31'd0, coef_err}, 32'd0);
    runLayer(16'h0100, 16'h0100, bits, lat);
    checkOutput("oorBankUnchanged", {28'd0, bits}, 32'b0001);
    consume();

    // Reset in the middle of a run clears state and the whole bank.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput("midRst", {27'd0, out_valid, busy, coef_err, out_bits == 4'b0 ? 2'b00 : 2'b11}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midRstReady", {30'd0, in_ready, busy}, 32'b10);
    runLayer(16'h0100, 16'h0100, bits, lat);
    checkOutput("midRstLatency", 32'(lat), 32'd5);
    checkOutput("midRstCoefZero", {28'd0, bits}, 32'd0);
    consume();

    // Back-to-back layers with both handshakes held high.
    loadLayer(vecs[1]);
    nAcc      = 0;
    nRes      = 0;
    in_a      = bbA[0];
    in_b      = bbB[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 60 && nRes < 3; k++) begin
      accNow = in_ready && in_valid;
      if (accNow) begin
        accCyc[nAcc] = cycle;
        nAcc++;
      end
      if (out_valid === 1'b1) begin
        if (in_ready === 1'b1) checkOutput("b2bNoOverlap", 32'd1, 32'd0);
        res[nRes] = out_bits;
        nRes++;
      end
      @(negedge clk);
      if (accNow) begin
        if (nAcc < 3) begin
          in_a = bbA[nAcc];
          in_b = bbB[nAcc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    checkOutput("b2bResults", 32'(nRes), 32'd3);
    checkOutput("b2bAccepts", 32'(nAcc), 32'd3);
    if (nAcc == 3) begin
      checkOutput("b2bSpacing1", 32'(accCyc[1] - accCyc[0]), 32'd6);
      checkOutput("b2bSpacing2", 32'(accCyc[2] - accCyc[1]), 32'd6);
    end
    for (int i = 0; i < nRes; i++) checkOutput($sformatf("b2bBits%0d", i), {28'd0, res[i]}, {28'd0, bbExp[i]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
